uart_rx: RTL

Asynchronous serial receiver, counterpart to the team's `uart_tx` transmitter.
- Samples an 8N1 line (1 start, 8 data LSB-first, 1 stop) at mid-bit and presents each received byte with a one-cycle valid strobe.
- Flags framing errors.
- Sits between the external RX pin and the byte consumer. Uses the same clocks-per-bit parameter as the transmitter, so a TX/RX pair with equal settings interoperates.

---
 rtl/uart_rx.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// 8N1 serial receiver: mid-bit sampling, one-cycle data_valid / frame_err strobes.
// Pairs with uart_tx when both use the same BAUD_RATE_DIV.
module uart_rx #(
  parameter int BAUD_RATE_DIV = 5208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int         HALF_DIV  = BAUD_RATE_DIV / 2;
  localparam logic [12:0] FULL_LAST = 13'(BAUD_RATE_DIV - 1);
  localparam logic [12:0] HALF_LAST = 13'(HALF_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  logic        rx_meta_reg;
  logic        rx_s_reg;

  state_t      state_reg, state_next;
  logic [12:0] cnt_reg, cnt_next;
  logic [2:0]  idx_reg, idx_next;
  logic [7:0]  shift_reg, shift_next;
  logic [7:0]  data_out_reg, data_out_next;
  logic        data_valid_reg, data_valid_next;
  logic        frame_err_reg, frame_err_next;

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_reg <= 1'b1;
      rx_s_reg    <= 1'b1;
    end else begin
      rx_meta_reg <= rx;
      rx_s_reg    <= rx_meta_reg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      idx_reg        <= '0;
      shift_reg      <= '0;
      data_out_reg   <= '0;
      data_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      idx_reg        <= idx_next;
      shift_reg      <= shift_next;
      data_out_reg   <= data_out_next;
      data_valid_reg <= data_valid_next;
      frame_err_reg  <= frame_err_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    idx_next        = idx_reg;
    shift_next      = shift_reg;
    data_out_next   = data_out_reg;
    data_valid_next = 1'b0;
    frame_err_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (!rx_s_reg) begin
          state_next = START;
          cnt_next   = '0;
          idx_next   = '0;
        end
      end

      // Half a bit in: a high line here means the low pulse was a glitch.
      START: begin
        if (cnt_reg == HALF_LAST) begin
          cnt_next   = '0;
          state_next = rx_s_reg ? IDLE : DATA;
        end else begin
          cnt_next = cnt_reg + 13'd1;
        end
      end

      DATA: begin
        if (cnt_reg == FULL_LAST) begin
          cnt_next            = '0;
          shift_next[idx_reg] = rx_s_reg;
          idx_next            = idx_reg + 3'd1;
          if (idx_reg == 3'd7) begin
            state_next = STOP;
          end
        end else begin
          cnt_next = cnt_reg + 13'd1;
        end
      end

      // Leave at mid-stop so a following start edge is not missed.
      STOP: begin
        if (cnt_reg == FULL_LAST) begin
          cnt_next = '0;
          if (rx_s_reg) begin
            data_out_next   = shift_reg;
            data_valid_next = 1'b1;
            state_next      = IDLE;
          end else begin
            frame_err_next = 1'b1;
            state_next     = WAIT_IDLE;
          end
        end else begin
          cnt_next = cnt_reg + 13'd1;
        end
      end

      // A break holds the line low; wait it out so it reports only once.
      WAIT_IDLE: begin
        if (rx_s_reg) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign data_out   = data_out_reg;
  assign data_valid = data_valid_reg;
  assign frame_err  = frame_err_reg;
  assign busy       = (state_reg != IDLE);

endmodule
